mc_control_irq: RTL

MC_CONTROL_IRQ -- requirements
Module: mc_control_irq

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/irq_prio_enc.sv | 32 +++
 rtl/mc_control_irq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit with interrupt support:
// state encoding, opcode constants, trap cause and PC source encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_INT_ENTRY = 4'd12,
    S_ERET      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    CAUSE_IRQ = 2'd0,
    CAUSE_NMI = 2'd1,
    CAUSE_ILL = 2'd2
  } cause_e;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_VEC    = 2'd3;

  // Last state of an instruction: the only points where an interrupt may be taken.
  function automatic logic is_terminal(input state_e s);
    return s inside {S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Masked priority encoder: the lowest-numbered enabled request wins.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  output logic         valid_o,
  output logic [3:0]   idx_o,
  output logic [N-1:0] onehot_o
);

  logic [N-1:0] active;
  assign active = req_i & mask_i;

  // Scan from the top down so the lowest active index is the final assignment.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred;
    // blocking assignments let later iterations override earlier ones.
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) begin
        valid_o     = 1'b1;
        idx_o       = 4'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_control_irq.sv
// Multicycle MIPS-style Moore control FSM with NMI, maskable IRQs,
// illegal-opcode trap and ERET return.
module mc_control_irq
  import mc_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 16,
  parameter logic [31:0] NMI_VEC    = 32'h0000_0080,
  parameter logic [31:0] ILL_VEC    = 32'h0000_00C0,
  parameter logic [5:0]  OP_ERET    = 6'd16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi,
  input  logic               busy,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               IorD,
  output logic               ALUSrcA,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               RegWrite,
  output logic [31:0]        vec_addr,
  output logic               save_epc,
  output logic               restore_epc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr,
  output logic [1:0]         cause,
  output logic [3:0]         current_state
);

  state_e               state_q, state_d;
  logic                 in_isr_q, in_isr_d;
  logic                 nmi_pend_q, nmi_pend_d;
  logic                 nmi_q;
  logic [31:0]          vec_q, vec_d;
  cause_e               cause_q, cause_d;
  logic [NUM_IRQ-1:0]   ack_q, ack_d;

  logic                 irq_valid;
  logic [3:0]           irq_idx;
  logic [NUM_IRQ-1:0]   irq_onehot;
  logic                 take_int;
  logic                 nmi_clr;

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req_i    (irq),
    .mask_i   (irq_mask),
    .valid_o  (irq_valid),
    .idx_o    (irq_idx),
    .onehot_o (irq_onehot)
  );

  // busy only defers maskable lines; a pending NMI is taken regardless.
  assign take_int = ~in_isr_q & (nmi_pend_q | (irq_valid & ~busy));

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (opcode == OP_ERET) state_d = in_isr_q ? S_ERET : S_FETCH;
            else                   state_d = in_isr_q ? S_FETCH : S_INT_ENTRY;
          end
        endcase
      end
      S_MEM_ADR:   state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default: begin
        if (is_terminal(state_q)) state_d = take_int ? S_INT_ENTRY : S_FETCH;
        else                      state_d = S_FETCH;
      end
    endcase
  end

  // Trap source selection, captured only on the edge that enters INT_ENTRY.
  always_comb begin
    vec_d   = vec_q;
    cause_d = cause_q;
    ack_d   = ack_q;
    nmi_clr = 1'b0;
    if (state_d == S_INT_ENTRY) begin
      if (state_q == S_DECODE) begin
        vec_d   = ILL_VEC;
        cause_d = CAUSE_ILL;
        ack_d   = '0;
      end else if (nmi_pend_q) begin
        vec_d   = NMI_VEC;
        cause_d = CAUSE_NMI;
        ack_d   = '0;
        nmi_clr = 1'b1;
      end else begin
        vec_d   = VEC_BASE + (32'(irq_idx) * 32'(VEC_STRIDE));
        cause_d = CAUSE_IRQ;
        ack_d   = irq_onehot;
      end
    end
  end

  // Handler flag and NMI edge memory; a new edge wins over a same-cycle clear.
  always_comb begin
    in_isr_d = in_isr_q;
    if (state_q == S_INT_ENTRY) in_isr_d = 1'b1;
    else if (state_q == S_ERET) in_isr_d = 1'b0;
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (nmi & ~nmi_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!rst_n) begin
      state_q    <= S_FETCH;
      in_isr_q   <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_q      <= 1'b0;
      vec_q      <= '0;
      cause_q    <= CAUSE_IRQ;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_isr_q   <= in_isr_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_q      <= nmi;
      vec_q      <= vec_d;
      cause_q    <= cause_d;
      ack_q      <= ack_d;
    end
  end

  // Moore output decode; everything is held at zero while reset is asserted.
  always_comb begin
    ALUOp         = 2'd0;
    ALUSrcB       = 2'd0;
    PCSrc         = PCSRC_ALU;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    IorD          = 1'b0;
    ALUSrcA       = 1'b0;
    IRWrite       = 1'b0;
    MemWrite      = 1'b0;
    PCWrite       = 1'b0;
    Branch        = 1'b0;
    RegWrite      = 1'b0;
    save_epc      = 1'b0;
    restore_epc   = 1'b0;
    irq_ack       = '0;
    vec_addr      = '0;
    cause         = 2'd0;
    in_isr        = 1'b0;
    current_state = 4'd0;
    if (rst_n) begin
      vec_addr      = vec_q;
      cause         = cause_q;
      in_isr        = in_isr_q;
      current_state = state_q;
      case (state_q)
        S_FETCH:     begin IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'd1; end
        S_DECODE:    ALUSrcB = 2'd3;
        S_MEM_ADR:   begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; end
        S_MEM_READ:  IorD = 1'b1;
        S_MEM_WB:    begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        S_MEM_WRITE: begin IorD = 1'b1; MemWrite = 1'b1; end
        S_EXECUTE:   begin ALUSrcA = 1'b1; ALUOp = 2'd2; end
        S_ALU_WB:    begin RegDst = 1'b1; RegWrite = 1'b1; end
        S_BRANCH:    begin ALUSrcA = 1'b1; ALUOp = 2'd1; Branch = 1'b1; PCSrc = PCSRC_ALUOUT; end
        S_ADDI_EXEC: begin ALUSrcA = 1'b1; ALUSrcB = 2'd2; end
        S_ADDI_WB:   RegWrite = 1'b1;
        S_JUMP:      begin PCWrite = 1'b1; PCSrc = PCSRC_JUMP; end
        S_INT_ENTRY: begin save_epc = 1'b1; PCWrite = 1'b1; PCSrc = PCSRC_VEC; irq_ack = ack_q; end
        S_ERET:      begin restore_epc = 1'b1; PCWrite = 1'b1; end
        default:     ;
      endcase
    end
  end

endmodule
